uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one fast_8N1_UART_TX instance between NUM_REQ byte producers, for example a debug dump, a command echo and a status reporter.
- Producers present bytes on independent valid/ready ports. The arbiter grants one producer per frame in round-robin order and drives TX_LOAD/TX_DATA, paced by LOAD_OK.
- A frame ends on a byte flagged req_last. Frames are never interleaved.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BYTE_W, 8, data width; must match the transmitter's BYTE_W
HOLDOFF, 2, cycles after a tx_load pulse during which tx_load_ok is ignored (covers LOAD_OK fall latency)
TIMEOUT, 1023, idle cycles inside an open frame before the grant is forcibly released
TAG_BASE, 8'h30, tag byte base value (optional feature only)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  arbitration enable
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*BYTE_W  packed bytes; requester i occupies bits [i*BYTE_W +: BYTE_W]
req_last  in  NUM_REQ  byte is last of frame; qualified by valid
req_ready  out  NUM_REQ  byte accepted this cycle (combinational from state, grant and tx_load_ok)
tx_load  out  1  one-cycle load strobe to transmitter TX_LOAD
tx_data  out  BYTE_W  byte to transmitter TX_DATA
tx_load_ok  in  1  transmitter LOAD_OK
grant_idx  out  clog2(NUM_REQ)  current or last grantee
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset, asynchronous and active-low. All outputs go low/zero, state IDLE, rr_ptr=0, timeout counter=0.
- Reset mid-frame drops any accepted-but-unloaded byte. tx_load deasserts immediately.
- FSM states: IDLE, (TAG), SEND, HOLD.
- IDLE:
  - Requires en=1 and |req_valid to leave.
  - Winner is the first asserted req_valid at or after rr_ptr, searching upward with wrap.
  - grant_idx<=winner; next state SEND, or TAG when the optional feature is compiled in.
  - One arbitration cycle. No ready is asserted in IDLE.
- SEND:
  - req_ready[g] = (state==SEND) && tx_load_ok && req_valid[g]. Every other ready bit is 0.
  - On the handshake: tx_data<=req_data[g], tx_load<=1 on the next edge, latch req_last[g] into last_q, go to HOLD.
  - The timeout counter increments each SEND cycle without a handshake and clears on a handshake.
  - When the count reaches TIMEOUT: go to IDLE, rr_ptr<=g+1 (mod NUM_REQ). The frame is abandoned and no byte is lost.
- HOLD:
  - tx_load is high for exactly the first HOLD cycle. The state lasts HOLDOFF cycles, and tx_load_ok is ignored throughout.
  - Exit to IDLE with rr_ptr<=g+1 (mod NUM_REQ) if last_q, else back to SEND.
- Latency: a valid byte arriving in IDLE with tx_load_ok=1 gives req_ready in cycle 1 and tx_load in cycle 2. Back-to-back bytes in a frame take 1+HOLDOFF cycles minimum, plus the transmitter's wait on LOAD_OK.
- en:
  - Sampled only in IDLE.
  - Dropping en mid-frame does not abort; the frame completes or times out.
- Simultaneous requests are resolved by round-robin only; there is no fixed priority.
- A requester deasserting valid mid-frame keeps the grant until it resumes or TIMEOUT expires.
- A single-byte frame (valid and last together) is legal.
- rr_ptr wraps NUM_REQ-1 -> 0.
- tx_data holds its value between loads.

Optional Feature:
- UART_ARB_TAG_EN defined:
  - Extra state TAG between IDLE and SEND.
  - In TAG, wait for tx_load_ok, then tx_data<=TAG_BASE+grant_idx with tx_load pulse, pass through HOLD, then enter SEND.
  - req_ready stays 0 during TAG and its HOLD.
  - Each frame on the wire is prefixed with its source tag.
- Undefined: no TAG state, TAG_BASE unused, first byte loads directly from SEND.

Test Plan:
- Single requester: req 1 sends "HI" (8'h48, then 8'h49 with last). Required response:
  - tx_load pulses carry 48 then 49, 1+HOLDOFF cycles apart with tx_load_ok held 1.
  - busy falls after the second HOLD and grant_idx=1.
- Contention, all 4 requesters valid with one-byte frames 8'hA0..8'hA3 from reset: load order A0,A1,A2,A3. A second identical round after rr_ptr=1 gives A1,A2,A3,A0.
- Frame lock: req 0 sends a 3-byte frame while req 2 is valid throughout. No req 2 byte is loaded until after req 0's last byte; req_ready[2] stays 0 the whole time.
- Backpressure: hold tx_load_ok=0 for 500 cycles while req 3 is valid. No tx_load and no req_ready during that time; release gives the load 1 cycle after the handshake.
- Timeout with TIMEOUT=15: req 1 sends one non-last byte, then drops valid. busy falls exactly 15 SEND cycles later, and a pending req 2 is granted next.
- Reset mid-HOLD: assert rst_n=0 during a tx_load pulse. tx_load, busy, req_ready and grant_idx are 0 immediately, and state is IDLE after release.
- With UART_ARB_TAG_EN: req 2 sends one byte 8'h55. Required loads are 8'h32 then 8'h55.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-atomic arbiter sharing one 8N1 UART transmitter between NUM_REQ producers.
// Define UART_ARB_TAG_EN to prefix every frame with a source tag byte (TAG_BASE + grantee).
module uart_tx_arbiter #(
  parameter int unsigned       NUM_REQ  = 4,
  parameter int unsigned       BYTE_W   = 8,
  parameter int unsigned       HOLDOFF  = 2,
  parameter int unsigned       TIMEOUT  = 1023,
  parameter logic [BYTE_W-1:0] TAG_BASE = BYTE_W'(8'h30)
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_load,
  output logic [BYTE_W-1:0]           tx_data,
  input  logic                        tx_load_ok,
  output logic [$clog2(NUM_REQ)-1:0]  grant_idx,
  output logic                        busy
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);
  localparam int unsigned HoldW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {StIdle, StSend, StHold, StTag} state_e;

  state_e           state_q;
  logic [IdxW-1:0]  rr_ptr_q;
  logic [TmoW-1:0]  tmo_q;
  logic [HoldW-1:0] hold_q;
  logic             last_q;
  logic             tag_q;

  logic [IdxW-1:0]   winner;
  logic [IdxW-1:0]   next_ptr;
  logic [BYTE_W-1:0] grant_byte;
  logic              handshake;

  // First asserted valid at or after rr_ptr, wrapping upward.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[IdxW'(idx)]) begin
        found  = 1'b1;
        winner = IdxW'(idx);
      end
    end
  end

  always_comb begin
    grant_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IdxW'(i) == grant_idx) grant_byte = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  assign next_ptr  = (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + IdxW'(1);
  assign handshake = (state_q == StSend) && tx_load_ok && req_valid[grant_idx];
  assign busy      = (state_q != StIdle);

  always_comb begin
    req_ready = '0;
    if (state_q == StSend && tx_load_ok) req_ready[grant_idx] = req_valid[grant_idx];
  end

`ifndef UART_ARB_TAG_EN
  logic [BYTE_W-1:0] unused_tag_base;
  assign unused_tag_base = TAG_BASE;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      tmo_q     <= '0;
      hold_q    <= '0;
      last_q    <= 1'b0;
      tag_q     <= 1'b0;
      tx_load   <= 1'b0;
      tx_data   <= '0;
      grant_idx <= '0;
    end else begin
      tx_load <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tmo_q <= '0;
          if (en && |req_valid) begin
            grant_idx <= winner;
`ifdef UART_ARB_TAG_EN
            state_q   <= StTag;
`else
            state_q   <= StSend;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        StTag: begin
          if (tx_load_ok) begin
            tx_data <= TAG_BASE + BYTE_W'(grant_idx);
            tx_load <= 1'b1;
            tag_q   <= 1'b1;
            hold_q  <= '0;
            state_q <= StHold;
          end
        end
`endif
        StSend: begin
          if (handshake) begin
            tx_data <= grant_byte;
            tx_load <= 1'b1;
            last_q  <= req_last[grant_idx];
            tmo_q   <= '0;
            hold_q  <= '0;
            state_q <= StHold;
          end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
            // Abandon the frame; nothing was accepted this cycle so no byte is lost.
            tmo_q    <= '0;
            rr_ptr_q <= next_ptr;
            state_q  <= StIdle;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StHold: begin
          if (hold_q == HoldW'(HOLDOFF - 1)) begin
            if (tag_q) begin
              tag_q   <= 1'b0;
              state_q <= StSend;
            end else if (last_q) begin
              rr_ptr_q <= next_ptr;
              state_q  <= StIdle;
            end else begin
              state_q <= StSend;
            end
          end else begin
            hold_q <= hold_q + HoldW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized frame mix
// checked against a round-robin frame-order model.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int BW   = 8;
  localparam int HOLD = 2;
  localparam int TMO  = 15;

  logic                 sys_clk = 1'b0;
  logic                 rst_n   = 1'b1;
  logic                 en      = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*BW-1:0]   req_data  = '0;
  logic [NREQ-1:0]      req_last  = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_load;
  logic [BW-1:0]        tx_data;
  logic                 tx_load_ok = 1'b0;
  logic [1:0]           grant_idx;
  logic                 busy;

  uart_tx_arbiter #(
    .NUM_REQ (NREQ),
    .BYTE_W  (BW),
    .HOLDOFF (HOLD),
    .TIMEOUT (TMO),
    .TAG_BASE(8'h30)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_load   (tx_load),
    .tx_data   (tx_data),
    .tx_load_ok(tx_load_ok),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  logic [7:0]      src_d [NREQ][$];
  bit              src_l [NREQ][$];
  logic [7:0]      ld_data[$];
  int              ld_cyc[$];
  int              fall_q[$];
  int              acc_q[$];
  logic [NREQ-1:0] acc    = '0;
  logic [NREQ-1:0] rdy_or = '0;
  int              rdy_cyc = 0;
  bit              busy_prev = 1'b0;
  int              ok_mode = 1;
  int              n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ld_at(input int k);
    return (k < ld_data.size()) ? 32'(ld_data[k]) : 32'hdead;
  endfunction

  function automatic int qi(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -9999;
  endfunction

  task automatic give(input int r, input logic [7:0] d, input bit l);
    src_d[r].push_back(d);
    src_l[r].push_back(l);
  endtask

  task automatic wait_loads(input int n, input int budget, input string tag);
    int k = 0;
    while (ld_data.size() < n && k < budget) begin
      @(posedge sys_clk);
      k++;
    end
    chk(tag, ld_data.size(), n);
  endtask

  task automatic reset_dut();
    @(posedge sys_clk);
    #1;
    rst_n   = 1'b0;
    en      = 1'b1;
    ok_mode = 1;
    for (int i = 0; i < NREQ; i++) begin
      src_d[i].delete();
      src_l[i].delete();
    end
    acc = '0;
    rdy_or = '0;
    acc_q.delete();
    ld_data.delete();
    ld_cyc.delete();
    fall_q.delete();
    busy_prev = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Producers + monitor: outputs sampled and inputs driven at negedge, ready sampled late in cycle.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (tx_load) begin
        ld_data.push_back(tx_data);
        ld_cyc.push_back(cyc);
      end
      if (busy_prev && !busy) fall_q.push_back(cyc);
      busy_prev = busy;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && src_d[i].size() > 0) begin
          void'(src_d[i].pop_front());
          void'(src_l[i].pop_front());
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (src_d[i].size() > 0) begin
          req_valid[i]           = 1'b1;
          req_data[i*BW +: BW]   = src_d[i][0];
          req_last[i]            = src_l[i][0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      tx_load_ok = (ok_mode == 1) || (ok_mode == 2 && $urandom_range(0, 3) != 0);
      #3;
      acc    = req_ready;
      rdy_or = rdy_or | req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          acc_q.push_back(i);
          rdy_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] mdl_d [NREQ][$];
    bit         mdl_l [NREQ][$];
    logic [7:0] exp_q[$];
    int         rr, w, len, k;
    logic [7:0] d;
    bit         l, done;

    reset_dut();
    chk("rst_tx_load", tx_load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_tx_data", tx_data, 0);

`ifndef UART_ARB_TAG_EN
    // Two-byte frame from a single requester.
    give(1, 8'h48, 1'b0);
    give(1, 8'h49, 1'b1);
    wait_loads(2, 60, "hi_wait");
    chk("hi_b0", ld_at(0), 8'h48);
    chk("hi_b1", ld_at(1), 8'h49);
    chk("hi_gap", qi(ld_cyc, 1) - qi(ld_cyc, 0), 1 + HOLD);
    repeat (4) @(posedge sys_clk);
    chk("hi_fall", qi(fall_q, 0) - qi(ld_cyc, 1), HOLD);
    chk("hi_grant", grant_idx, 1);
    chk("hi_busy", busy, 0);

    // Round-robin contention from reset, then again from rr_ptr=1.
    reset_dut();
    for (int i = 0; i < NREQ; i++) give(i, 8'hA0 + 8'(i), 1'b1);
    wait_loads(4, 100, "rr1_wait");
    for (int i = 0; i < NREQ; i++) chk("rr1_order", ld_at(i), 8'hA0 + i);
    give(0, 8'hB0, 1'b1);
    wait_loads(5, 50, "rr_b0_wait");
    for (int i = 0; i < NREQ; i++) give(i, 8'hA0 + 8'(i), 1'b1);
    wait_loads(9, 100, "rr2_wait");
    for (int i = 0; i < NREQ; i++) chk("rr2_order", ld_at(5 + i), 8'hA0 + ((i + 1) % NREQ));

    // Frame lock: req 2 waits for req 0's whole frame.
    reset_dut();
    give(0, 8'hC0, 1'b0);
    give(0, 8'hC1, 1'b0);
    give(0, 8'hC2, 1'b1);
    give(2, 8'hD0, 1'b1);
    wait_loads(4, 100, "lock_wait");
    chk("lock_b0", ld_at(0), 8'hC0);
    chk("lock_b1", ld_at(1), 8'hC1);
    chk("lock_b2", ld_at(2), 8'hC2);
    chk("lock_b3", ld_at(3), 8'hD0);
    chk("lock_acc_n", acc_q.size(), 4);
    for (int i = 0; i < 3; i++) chk("lock_acc", qi(acc_q, i), 0);
    chk("lock_acc3", qi(acc_q, 3), 2);

    // Backpressure: LOAD_OK low for 500 cycles.
    reset_dut();
    ok_mode = 0;
    give(3, 8'hE3, 1'b1);
    repeat (500) @(posedge sys_clk);
    chk("bp_noload", ld_data.size(), 0);
    chk("bp_noready", rdy_or, 0);
    ok_mode = 1;
    wait_loads(1, 60, "bp_wait");
    chk("bp_data", ld_at(0), 8'hE3);
    chk("bp_lat", qi(ld_cyc, 0) - rdy_cyc, 1);

    // Timeout: req 1 stalls after a non-last byte, req 2 pending.
    reset_dut();
    give(1, 8'hF1, 1'b0);
    give(2, 8'hF2, 1'b1);
    wait_loads(2, 100, "to_wait");
    chk("to_b0", ld_at(0), 8'hF1);
    chk("to_b1", ld_at(1), 8'hF2);
    chk("to_fall", qi(fall_q, 0) - qi(ld_cyc, 0), HOLD + TMO);
    chk("to_grant", grant_idx, 2);

    // Reset asserted while tx_load is high.
    reset_dut();
    give(1, 8'h77, 1'b1);
    k = 0;
    while (!tx_load && k < 50) begin
      @(posedge sys_clk);
      #1;
      k++;
    end
    chk("rm_seen", tx_load, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_tx_load", tx_load, 0);
    chk("rm_busy", busy, 0);
    chk("rm_ready", req_ready, 0);
    chk("rm_grant", grant_idx, 0);
    reset_dut();
    repeat (5) @(posedge sys_clk);
    chk("rm_idle", busy, 0);
    chk("rm_noload", ld_data.size(), 0);
    give(2, 8'h99, 1'b1);
    wait_loads(1, 30, "rm_resume");
    chk("rm_data", ld_at(0), 8'h99);
`else
    give(2, 8'h55, 1'b1);
    wait_loads(2, 60, "tag_wait");
    chk("tag_b0", ld_at(0), 8'h32);
    chk("tag_b1", ld_at(1), 8'h55);
`endif

    // Randomized frames on all requesters with random LOAD_OK.
    reset_dut();
    ok_mode = 2;
    for (int i = 0; i < NREQ; i++) begin
      for (int f = 0; f < 3; f++) begin
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) begin
          d = 8'($urandom_range(0, 255));
          l = (b == len - 1);
          give(i, d, l);
          mdl_d[i].push_back(d);
          mdl_l[i].push_back(l);
        end
      end
    end
    // Model: whole frames granted round-robin among requesters that still have data.
    rr = 0;
    done = 1'b0;
    while (!done) begin
      w = -1;
      for (int j = 0; j < NREQ; j++) begin
        if (w < 0 && mdl_d[(rr + j) % NREQ].size() > 0) w = (rr + j) % NREQ;
      end
      if (w < 0) begin
        done = 1'b1;
      end else begin
`ifdef UART_ARB_TAG_EN
        exp_q.push_back(8'h30 + 8'(w));
`endif
        l = 1'b0;
        while (!l) begin
          exp_q.push_back(mdl_d[w].pop_front());
          l = mdl_l[w].pop_front();
        end
        rr = (w + 1) % NREQ;
      end
    end
    wait_loads(exp_q.size(), 3000, "rnd_wait");
    for (int i = 0; i < exp_q.size(); i++) chk("rnd_byte", ld_at(i), 32'(exp_q[i]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
